// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch time-keeping core.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } sw_state_t;

   localparam int unsigned SEC_W = 6;
   localparam int unsigned MIN_W = 6;

endpackage

// File: rtl/stopwatch_counter_mod_counter.sv
// mod_counter: modulo-(MAX+1) counter with synchronous clear and count enable.
// tc is high while the count sits at MAX, so en & tc is the carry out.
module mod_counter #(
   parameter int unsigned W   = 6,
   parameter int unsigned MAX = 59
) (
   input  logic         clock_in,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc  = (cnt_q == W'(MAX));
   assign cnt = cnt_q;

   // Next count: clear wins, otherwise wrap at MAX or increment when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS time-keeping core fed by the clock divider level.
// Optional lap-freeze of the displayed value is built with STOPWATCH_LAP_EN.
import stopwatch_pkg::*;

module stopwatch_counter #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned SEC_MAX       = 59,
   parameter int unsigned MIN_MAX       = 59
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   output logic [SEC_W-1:0] sec_o,
   output logic [MIN_W-1:0] min_o,
   output logic             running,
   output logic             wrap_o
);

   localparam int unsigned PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   sw_state_t        state_q;
   logic             running_q;
   logic             tick_q;
   logic             tick_pls;
   logic             cnt_en;
   logic [PS_W-1:0]  prescale_q;
   logic [PS_W-1:0]  prescale_d;
   logic             ps_tc;
   logic             sec_en;
   logic             min_en;
   logic             sec_tc;
   logic             min_tc;
   logic             wrap_q;
   logic             wrap_d;
   logic [SEC_W-1:0] sec_cnt;
   logic [MIN_W-1:0] min_cnt;

   assign tick_pls = tick_in & ~tick_q;
   // The state seen at the tick edge decides counting, so a start_stop on
   // the same edge counts the tick when leaving RUNNING but not when entering.
   assign cnt_en   = (state_q == RUNNING) & tick_pls & ~clear;
   assign ps_tc    = (prescale_q == PS_W'(TICKS_PER_SEC - 1));
   assign sec_en   = cnt_en & ps_tc;
   assign min_en   = sec_en & sec_tc;
   assign wrap_d   = min_en & min_tc;

   // Prescale next value: divides tick pulses down to one second step.
   always_comb begin
      prescale_d = prescale_q;
      if (clear)
         prescale_d = '0;
      else if (cnt_en)
         prescale_d = ps_tc ? '0 : prescale_q + PS_W'(1);
   end

   // Tick edge history, prescale and wrap pulse registers.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         tick_q     <= 1'b0;
         prescale_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         tick_q     <= tick_in;
         prescale_q <= prescale_d;
         wrap_q     <= wrap_d;
      end
   end

   // Run/pause/clear state machine with registered running flag.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
      end else if (clear) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
      end else if (start_stop) begin
         case (state_q)
            IDLE, PAUSED: begin
               state_q   <= RUNNING;
               running_q <= 1'b1;
            end
            RUNNING: begin
               state_q   <= PAUSED;
               running_q <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clock_in (clock_in),
      .reset    (reset),
      .clr      (clear),
      .en       (sec_en),
      .cnt      (sec_cnt),
      .tc       (sec_tc)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clock_in (clock_in),
      .reset    (reset),
      .clr      (clear),
      .en       (min_en),
      .cnt      (min_cnt),
      .tc       (min_tc)
   );

`ifdef STOPWATCH_LAP_EN
   logic             lap_hold_q;
   logic [SEC_W-1:0] sec_hold_q;
   logic [MIN_W-1:0] min_hold_q;

   // Lap toggles a freeze of the displayed value; live counting carries on.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         lap_hold_q <= 1'b0;
         sec_hold_q <= '0;
         min_hold_q <= '0;
      end else if (clear) begin
         lap_hold_q <= 1'b0;
      end else if (lap && (state_q != IDLE)) begin
         lap_hold_q <= ~lap_hold_q;
         if (!lap_hold_q) begin
            sec_hold_q <= sec_cnt;
            min_hold_q <= min_cnt;
         end
      end
   end

   assign sec_o = lap_hold_q ? sec_hold_q : sec_cnt;
   assign min_o = lap_hold_q ? min_hold_q : min_cnt;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign sec_o      = sec_cnt;
   assign min_o      = min_cnt;
`endif

   assign running = running_q;
   assign wrap_o  = wrap_q;

endmodule
